// File: rtl/sr_pkg.sv
// Shared definitions for the universal shift register family.
// Provides the 3-bit operation-select encodings used by RTL and bench.
package sr_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;

endpackage

// File: rtl/sr_word_counter.sv
// Word-framing counter: counts shift/rotate operations and pulses
// word_done for one cycle after every WIDTH counted operations.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   op_c        - a counted operation happens this cycle
//   clr_c       - restart framing (load); wins over op_c
//   cnt         - operations since last clear/reset/wrap (registered)
//   word_done   - one-cycle word-boundary pulse (registered)
module sr_word_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_c,
  input  logic             clr_c,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_done_q, word_done_d;

  // Pulse defaults low every cycle so it can never stretch.
  always_comb begin
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    if (clr_c) begin
      cnt_d = '0;
    end else if (op_c) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d       = '0;
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign cnt       = cnt_q;
  assign word_done = word_done_q;

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised universal shift register with word-boundary framing.
// Modes: hold, shift left/right, parallel load, rotate left/right;
// reserved mode codes hold q and set a sticky error flag.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   en                 - clock enable (0 freezes q, cnt, err)
//   mode               - operation select (sr_pkg MODE_*)
//   sin_lsb, sin_msb   - serial inputs for shift left / shift right
//   pdin               - parallel load data
//   q                  - register contents (registered)
//   sout_msb, sout_lsb - serial outputs, combinational from q
//   cnt, word_done     - word framing counter and pulse (registered)
//   err                - sticky illegal-mode flag (registered)
module param_shift_reg
  import sr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int unsigned     CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_lsb,
  input  logic              sin_msb,
  input  logic [WIDTH-1:0]  pdin,
  output logic [WIDTH-1:0]  q,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic [CNT_W-1:0]  cnt,
  output logic              word_done,
  output logic              err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             cnt_op_c, cnt_clr_c;

  // Next-state mux; reserved codes are fully defined (hold + flag).
  always_comb begin
    q_d       = q_q;
    err_d     = err_q;
    cnt_op_c  = 1'b0;
    cnt_clr_c = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin_lsb};
          cnt_op_c = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin_msb, q_q[WIDTH-1:1]};
          cnt_op_c = 1'b1;
        end
        MODE_LOAD: begin
          q_d       = pdin;
          cnt_clr_c = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cnt_op_c = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          cnt_op_c = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  sr_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_word_counter (
    .clk       (clk),
    .rst       (rst),
    .op_c      (cnt_op_c),
    .clr_c     (cnt_clr_c),
    .cnt       (cnt),
    .word_done (word_done)
  );

  assign q        = q_q;
  assign err      = err_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed self-checking bench for param_shift_reg at WIDTH=4.
module tb_param_shift_reg;
  import sr_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [2:0]       mode = MODE_HOLD;
  logic             sin_lsb = 1'b0;
  logic             sin_msb = 1'b0;
  logic [WIDTH-1:0] pdin = '0;
  logic [WIDTH-1:0] q;
  logic             sout_msb, sout_lsb;
  logic [CNT_W-1:0] cnt;
  logic             word_done;
  logic             err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  param_shift_reg #(.WIDTH(WIDTH), .RST_VAL(4'b0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .pdin      (pdin),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .cnt       (cnt),
    .word_done (word_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] eq,
                     input int ecnt, input logic ewd);
    check({tag, ".q"},   32'(q),         32'(eq));
    check({tag, ".cnt"}, 32'(cnt),       32'(ecnt));
    check({tag, ".wd"},  32'(word_done), 32'(ewd));
  endtask

  // Apply one set of inputs across a rising edge, then sample 1 time unit later.
  task automatic step(input logic e, input logic [2:0] m, input logic sl,
                      input logic sm, input logic [WIDTH-1:0] pd);
    en = e; mode = m; sin_lsb = sl; sin_msb = sm; pdin = pd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst0", 4'b0000, 0, 1'b0);
    check("rst0.err", 32'(err), 32'(0));
    @(negedge clk) rst = 1'b0;

    // Load 1011, then shift left with sin_lsb 1,0,0,1.
    step(1, MODE_LOAD, 0, 0, 4'b1011); chk("ld1011", 4'b1011, 0, 0);
    step(1, MODE_SHL, 1, 0, 0);        chk("shl1", 4'b0111, 1, 0);
    check("shl1.msb", 32'(sout_msb), 32'(0));
    step(1, MODE_SHL, 0, 0, 0);        chk("shl2", 4'b1110, 2, 0);
    check("shl2.msb", 32'(sout_msb), 32'(1));
    step(1, MODE_SHL, 0, 0, 0);        chk("shl3", 4'b1100, 3, 0);
    check("shl3.msb", 32'(sout_msb), 32'(1));
    step(1, MODE_SHL, 1, 0, 0);        chk("shl4", 4'b1001, 0, 1);
    check("shl4.msb", 32'(sout_msb), 32'(1));
    step(1, MODE_HOLD, 0, 0, 0);       chk("hold", 4'b1001, 0, 0);

    // Load 1000, rotate right four times back to the original.
    step(1, MODE_LOAD, 0, 0, 4'b1000); chk("ld1000", 4'b1000, 0, 0);
    step(1, MODE_ROR, 0, 0, 0);        chk("ror1", 4'b0100, 1, 0);
    step(1, MODE_ROR, 0, 0, 0);        chk("ror2", 4'b0010, 2, 0);
    step(1, MODE_ROR, 0, 0, 0);        chk("ror3", 4'b0001, 3, 0);
    check("ror3.lsb", 32'(sout_lsb), 32'(1));
    step(1, MODE_ROR, 0, 0, 0);        chk("ror4", 4'b1000, 0, 1);
    check("ror4.lsb", 32'(sout_lsb), 32'(0));

    // Shift right with sin_msb=1, freeze with en=0, then finish the word.
    step(1, MODE_LOAD, 0, 0, 4'b0000); chk("ld0000", 4'b0000, 0, 0);
    step(1, MODE_SHR, 0, 1, 0);        chk("shr1", 4'b1000, 1, 0);
    step(1, MODE_SHR, 0, 1, 0);        chk("shr2", 4'b1100, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, MODE_SHR, 0, 1, 0);      chk("en0", 4'b1100, 2, 0);
    end
    step(1, MODE_SHR, 0, 1, 0);        chk("shr3", 4'b1110, 3, 0);
    step(1, MODE_SHR, 0, 1, 0);        chk("shr4", 4'b1111, 0, 1);

    // Load mid-word restarts framing.
    step(1, MODE_SHL, 0, 0, 0);        chk("pre1", 4'b1110, 1, 0);
    step(1, MODE_SHL, 0, 0, 0);        chk("pre2", 4'b1100, 2, 0);
    step(1, MODE_SHL, 0, 0, 0);        chk("pre3", 4'b1000, 3, 0);
    step(1, MODE_LOAD, 0, 0, 4'b0101); chk("ld0101", 4'b0101, 0, 0);
    step(1, MODE_ROL, 0, 0, 0);        chk("rol1", 4'b1010, 1, 0);
    step(1, MODE_ROL, 0, 0, 0);        chk("rol2", 4'b0101, 2, 0);
    step(1, MODE_ROL, 0, 0, 0);        chk("rol3", 4'b1010, 3, 0);
    step(1, MODE_ROL, 0, 0, 0);        chk("rol4", 4'b0101, 0, 1);

    // Illegal modes: q held, err sticky through legal operations.
    step(1, 3'b110, 0, 0, 0);          chk("ill6", 4'b0101, 0, 0);
    check("ill6.err", 32'(err), 32'(1));
    step(1, 3'b111, 0, 0, 0);          chk("ill7", 4'b0101, 0, 0);
    step(1, MODE_SHL, 1, 0, 0);        chk("post", 4'b1011, 1, 0);
    check("post.err", 32'(err), 32'(1));

    // Async reset mid-word clears everything before the next edge.
    #2 rst = 1'b1;
    #1;
    chk("rst1", 4'b0000, 0, 0);
    check("rst1.err", 32'(err), 32'(0));
    @(negedge clk) rst = 1'b0;

    // Mixed directions count into one word; partial word was discarded.
    step(1, MODE_SHL, 1, 0, 0);        chk("mix1", 4'b0001, 1, 0);
    step(1, MODE_SHR, 0, 0, 0);        chk("mix2", 4'b0000, 2, 0);
    step(1, MODE_ROL, 0, 0, 0);        chk("mix3", 4'b0000, 3, 0);
    step(1, MODE_ROR, 0, 0, 0);        chk("mix4", 4'b0000, 0, 1);
    step(0, MODE_ROR, 0, 0, 0);        chk("mix5", 4'b0000, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
